// File: rtl/reflex_pkg.sv
// Shared definitions for the reaction-time readout: FSM states, BCD saturation
// constant and the active-low 7-segment patterns.
package reflex_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_DATA,
        S_CONVERT,
        S_DISPLAY
    } state_t;

    localparam logic [15:0] BCD_SAT   = 16'h9999;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Segment order {g,f,e,d,c,b,a}, low = lit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_ZERO;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit display scan: prescaler, digit rotation and registered
// segment decode of the selected BCD nibble.
module seg7_scan
    import reflex_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        ck,
    input  logic        reset,
    input  logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescale;
    logic [1:0]    digit;
    logic [1:0]    digit_nx;
    logic          wrap;

    always_comb begin
        wrap     = (prescale == PW'(REFRESH_DIV - 1));
        digit_nx = wrap ? digit + 2'd1 : digit;
    end

    // an and seg are both derived from digit_nx so they stay aligned.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            digit    <= '0;
            an       <= 4'b1110;
            seg      <= SEG_ZERO;
        end else begin
            prescale <= wrap ? '0 : prescale + PW'(1);
            digit    <= digit_nx;
            an       <= ~(4'b0001 << digit_nx);
            seg      <= seg_decode(bcd[{digit_nx, 2'b00} +: 4]);
        end
    end

endmodule

// File: rtl/reflex_readout.sv
// Reads stored reaction times or the error count, converts them to BCD with a
// sequential double-dabble and drives the 4-digit multiplexed display.
module reflex_readout
    import reflex_pkg::*;
#(
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              ck,
    input  logic              reset,
    input  logic              next,
    input  logic              sel_err,
    input  logic [ADDR_W:0]   valid_count,
    input  logic [DATA_W-1:0] errors,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic [15:0]       bcd,
    output logic [6:0]        seg,
    output logic [3:0]        an
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    state_t            state;
    logic [DATA_W-1:0] bin;
    logic [DATA_W-1:0] bin_shift;
    logic [DATA_W-1:0] err_q;
    logic [15:0]       bcd_work;
    logic [15:0]       bcd_adj;
    logic [15:0]       bcd_shift;
    logic [CW-1:0]     cnt;
    logic              sat;
    logic              pending;
    logic              sel_q;
    logic              sel_edge;
    logic              vc_zero;
    logic [ADDR_W:0]   addr_ext;
    logic              go_err;
    logic              go_read;
    logic              go_zero;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic over_sat(input logic [DATA_W-1:0] v);
        return 32'(v) > 32'd9999;
    endfunction

    always_comb begin
        bcd_adj = bcd_work;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
        {bcd_shift, bin_shift} = {bcd_adj, bin} << 1;
    end

    // Start decisions for the two resting states; pending is treated like a
    // fresh selection edge so it reuses the same paths.
    always_comb begin
        sel_edge = (sel_err != sel_q);
        vc_zero  = (valid_count == '0);
        addr_ext = {1'b0, mem_addr};
        go_err   = 1'b0;
        go_read  = 1'b0;
        go_zero  = 1'b0;
        rd_addr  = mem_addr;
        case (state)
            S_IDLE: begin
                if (sel_err) begin
                    go_err = 1'b1;
                end else if (next) begin
                    go_zero = vc_zero;
                    go_read = !vc_zero;
                    rd_addr = '0;
                end
            end
            S_DISPLAY: begin
                if (sel_err) begin
                    go_err = pending || sel_edge || (errors != err_q);
                end else if (pending || sel_edge) begin
                    go_zero = vc_zero;
                    go_read = !vc_zero;
                    rd_addr = (addr_ext >= valid_count) ? '0 : mem_addr;
                end else if (next) begin
                    go_zero = vc_zero;
                    go_read = !vc_zero;
                    rd_addr = (addr_ext + (ADDR_W+1)'(1) >= valid_count) ? '0
                                                                         : mem_addr + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            bcd      <= '0;
            pending  <= 1'b0;
            sel_q    <= 1'b0;
            err_q    <= '0;
            bin      <= '0;
            bcd_work <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            sel_q  <= sel_err;
            if (busy && sel_edge)
                pending <= 1'b1;
            case (state)
                S_IDLE, S_DISPLAY: begin
                    pending <= 1'b0;
                    if (go_err) begin
                        bin      <= errors;
                        err_q    <= errors;
                        sat      <= over_sat(errors);
                        bcd_work <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_CONVERT;
                    end else if (go_read) begin
                        mem_addr <= rd_addr;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_READ;
                    end else if (go_zero) begin
                        bcd   <= '0;
                        state <= S_DISPLAY;
                    end
                end
                S_READ: state <= S_WAIT_DATA;
                S_WAIT_DATA: begin
                    bin      <= mem_data;
                    sat      <= over_sat(mem_data);
                    bcd_work <= '0;
                    cnt      <= '0;
                    state    <= S_CONVERT;
                end
                S_CONVERT: begin
                    bcd_work <= bcd_shift;
                    bin      <= bin_shift;
                    cnt      <= cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        bcd   <= sat ? BCD_SAT : bcd_shift;
                        busy  <= 1'b0;
                        state <= S_DISPLAY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    seg7_scan #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .ck   (ck),
        .reset(reset),
        .bcd  (bcd),
        .seg  (seg),
        .an   (an)
    );

endmodule

// File: doc/reflex_readout.md
Name: reflex_readout

Overview:
- Read-side counterpart of the reaction-time measurement controller.
- Reads stored reaction times (ms) out of the results memory that the measurement FSM writes, or takes the error count, and converts the value to 4 BCD digits with a sequential double-dabble.
- Drives a multiplexed 4-digit active-low 7-segment display.
- The user steps through stored entries with a `next` pulse and selects time or error view with `sel_err`.

Parameters:
- DATA_W, 14, width of stored reaction time and of error count.
- ADDR_W, 3, results memory address width; depth = 2**ADDR_W.
- REFRESH_DIV, 100000, ck cycles per digit in the display scan; must be >= 2.

Ports:
- ck  in  1  clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- next  in  1  single-cycle pulse (already debounced): show next stored entry
- sel_err  in  1  level; 0 = show reaction time, 1 = show error count
- valid_count  in  ADDR_W+1  number of valid entries in memory (0..2**ADDR_W)
- errors  in  DATA_W  current error count from the measurement path
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_data  in  DATA_W  read data, valid exactly 1 cycle after the cycle in which mem_rd is high
- busy  out  1  high while a fetch/conversion is in progress
- bcd  out  16  displayed digits {thousands, hundreds, tens, units}
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- an  out  4  active-low digit enables; an[0] = units

Behaviour:
- Reset values (asynchronous):
  - state IDLE, mem_addr 0, mem_rd 0, busy 0, bcd 16'h0000, pending 0.
  - prescaler 0, digit index 0, an 4'b1110, seg 7'b1000000 (shows "0").
- FSM states: IDLE, READ, WAIT_DATA, CONVERT, DISPLAY.
- IDLE:
  - next=1 and valid_count!=0 -> READ with mem_addr=0.
  - next=1 and valid_count==0 -> DISPLAY with bcd=0.
  - sel_err=1 -> CONVERT with errors loaded.
- READ (1 cycle): mem_rd=1 -> WAIT_DATA.
- WAIT_DATA (1 cycle): capture mem_data into the binary shift register -> CONVERT.
- CONVERT: exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd_work, bin} left by 1. After the last cycle, load bcd -> DISPLAY.
- Saturation: if the captured value is >9999, skip the arithmetic result and load bcd=16'h9999. Timing is unchanged: CONVERT still lasts DATA_W cycles.
- Latency: next asserted in cycle 0 -> mem_rd in cycle 1 -> capture in cycle 2 -> CONVERT cycles 3..16 -> new bcd visible in cycle 17 (DATA_W=14).
- For the errors path, no memory access: CONVERT is entered directly, and new bcd is visible DATA_W+1 cycles after the trigger.
- busy=1 in READ, WAIT_DATA, CONVERT. bcd holds its previous value until the final load.
- DISPLAY, sel_err=0:
  - next advances mem_addr; it wraps to 0 when mem_addr == valid_count-1.
  - If valid_count==0, next is ignored and bcd is forced to 0.
  - Otherwise -> READ.
- DISPLAY, sel_err=1:
  - next ignored.
  - errors is reconverted whenever errors changes (compared against a registered copy).
- sel_err edge in DISPLAY or IDLE -> conversion of the newly selected source. For time, mem_addr is unchanged; go through READ.
- next while busy: ignored, not queued.
- sel_err edge while busy: sets pending. On entering DISPLAY with pending=1, clear pending and start a conversion of the current selection on the next cycle.
- valid_count shrinking below mem_addr+1 (memory cleared): on the next read, mem_addr is reset to 0.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. On wrap, digit index increments mod 4 and an rotates.
  - seg = decode(bcd nibble of the current digit), registered with an.
  - Leading zeros are displayed.
  - Nibble values >9 decode to all segments off (7'b1111111).
- reset asserted mid-conversion: all state returns to reset values immediately. No partial bcd update.

Decomposition:
- Package reflex_pkg:
  - FSM state encodings.
  - 7-segment patterns for 0-9 and blank (active-low).
  - Constant BCD_SAT = 16'h9999.
- Sub-module seg7_scan: owns the prescaler, digit index, an and seg decode. It takes bcd as input.
- The double-dabble stays inside reflex_readout, since it is sequenced by the FSM.

Test Plan:
- Reset, no stimulus -> bcd=0000, an cycles 1110,1101,1011,0111 every REFRESH_DIV cycles (bench uses REFRESH_DIV=4), seg=7'b1000000 on every digit.
- valid_count=3, memory {0:245, 1:1000, 2:37}; next pulse -> mem_rd in cycle 1, bcd=16'h0245 in cycle 17; next -> 16'h1000; next -> 16'h0037; next -> addr wraps to 0, 16'h0245.
- Memory word 12000 -> bcd=16'h9999 after the same 17-cycle latency.
- sel_err 0->1 with errors=7 -> bcd=16'h0007 after 15 cycles; errors changes to 8 -> bcd=16'h0008; next pulses ignored, mem_rd stays 0.
- next pulse and sel_err toggle during CONVERT -> the next pulse is dropped, mem_addr is unchanged, and a pending reconversion produces the newly selected value after DISPLAY is re-entered.
- valid_count=0, next -> no mem_rd, bcd=0000. Reset asserted in cycle 8 of a conversion -> bcd=0000 and state IDLE with no further update.
